// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game sequencer.
// Holds the FSM encoding, LFSR constants and the best-time reset value.
package reaction_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitLed,
        StMeasure,
        StDone
    } state_e;

    localparam logic [7:0]  LFSR_SEED = 8'h01;
    // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;
    localparam logic [15:0] BEST_INIT = 16'hFFFF;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        logic fb;
        fb = ^(cur & LFSR_TAPS);
        return {cur[6:0], fb};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; a maximal-length sequence, so it never reads zero.
module lfsr8
    import reaction_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= LFSR_SEED;
        end else begin
            out <= lfsr_next(out);
        end
    end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-game sequencer: arms the LED delay, times the player's press, tracks the best time.
// Flags false starts and timeouts; all outputs come straight from registers.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000,
    parameter logic [7:0]  MIN_DELAY = 8'd32,
    parameter logic [15:0] TIMEOUT   = 16'd2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        react,
    input  logic        led_on,
    output logic        lighter_en,
    output logic [7:0]  delay_num,
    output logic [15:0] rt,
    output logic [15:0] best,
    output logic        result_valid,
    output logic        false_start,
    output logic        timed_out,
    output logic        busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_e        state;
    logic          start_q;
    logic          react_q;
    logic [PW-1:0] pre_q;
    logic [15:0]   tick_q;
    logic [7:0]    lfsr_val;
    logic          start_edge;
    logic          react_edge;
    logic [7:0]    delay_pick;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .out   (lfsr_val)
    );

    assign start_edge = start & ~start_q;
    assign react_edge = react & ~react_q;
    assign delay_pick = (lfsr_val < MIN_DELAY) ? MIN_DELAY : lfsr_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            start_q      <= 1'b0;
            react_q      <= 1'b0;
            pre_q        <= '0;
            tick_q       <= '0;
            lighter_en   <= 1'b0;
            delay_num    <= 8'h00;
            rt           <= 16'h0000;
            best         <= BEST_INIT;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timed_out    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            start_q      <= start;
            react_q      <= react;
            result_valid <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (start_edge) begin
                        delay_num   <= delay_pick;
                        false_start <= 1'b0;
                        timed_out   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= StArm;
                    end
                end

                StArm: begin
                    lighter_en <= 1'b1;
                    state      <= StWaitLed;
                end

                StWaitLed: begin
                    if (react_edge && !led_on) begin
                        false_start  <= 1'b1;
                        result_valid <= 1'b1;
                        rt           <= 16'h0000;
                        lighter_en   <= 1'b0;
                        busy         <= 1'b0;
                        state        <= StIdle;
                    end else if (led_on) begin
                        pre_q  <= '0;
                        tick_q <= '0;
                        if (react_edge) begin
                            // Press coincident with the LED: a valid zero-tick result.
                            rt         <= 16'h0000;
                            lighter_en <= 1'b0;
                            busy       <= 1'b0;
                            state      <= StDone;
                        end else begin
                            state <= StMeasure;
                        end
                    end
                end

                StMeasure: begin
                    if (tick_q == TIMEOUT) begin
                        timed_out    <= 1'b1;
                        rt           <= TIMEOUT;
                        result_valid <= 1'b1;
                        lighter_en   <= 1'b0;
                        busy         <= 1'b0;
                        state        <= StIdle;
                    end else if (react_edge) begin
                        rt         <= tick_q;
                        lighter_en <= 1'b0;
                        busy       <= 1'b0;
                        state      <= StDone;
                    end else if (pre_q == PRE_LAST) begin
                        pre_q  <= '0;
                        tick_q <= tick_q + 16'd1;
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end

                StDone: begin
                    result_valid <= 1'b1;
                    if (rt < best) begin
                        best <= rt;
                    end
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl with a behavioural LED delay counter attached.
// Expected results are queued as stimulus is applied and popped on each result_valid pulse.
module tb_reaction_ctrl;

    localparam int unsigned TB_TICK_DIV = 4;
    localparam logic [15:0] TB_TIMEOUT  = 16'd20;

    typedef struct packed {
        logic [15:0] rt;
        logic        fs;
        logic        to;
        logic [15:0] best;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        react = 1'b0;
    logic        led_on = 1'b0;
    logic        lighter_en;
    logic [7:0]  delay_num;
    logic [15:0] rt;
    logic [15:0] best;
    logic        result_valid;
    logic        false_start;
    logic        timed_out;
    logic        busy;

    logic [7:0]  lit_cnt = 8'h00;
    logic [7:0]  m_lfsr;
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    reaction_ctrl #(
        .TICK_DIV  (TB_TICK_DIV),
        .MIN_DELAY (8'd32),
        .TIMEOUT   (TB_TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .react        (react),
        .led_on       (led_on),
        .lighter_en   (lighter_en),
        .delay_num    (delay_num),
        .rt           (rt),
        .best         (best),
        .result_valid (result_valid),
        .false_start  (false_start),
        .timed_out    (timed_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // LED delay counter: held clear while disabled, lights once the count reaches num.
    always @(posedge clk) begin
        if (!lighter_en) begin
            lit_cnt <= 8'h00;
            led_on  <= 1'b0;
        end else if (lit_cnt == delay_num) begin
            led_on <= 1'b1;
        end else begin
            lit_cnt <= lit_cnt + 8'd1;
        end
    end

    // Reference LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded with 1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'h01;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_led(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (led_on) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic wait_rv(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (result_valid) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (lighter_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_lighter_en got %b want 0", lighter_en);
        end
        n_checks++;
        if (delay_num !== 8'h00) begin
            n_fail++; $display("FAIL reset_delay_num got %h want 00", delay_num);
        end
        n_checks++;
        if (rt !== 16'h0000) begin
            n_fail++; $display("FAIL reset_rt got %h want 0000", rt);
        end
        n_checks++;
        if (best !== 16'hFFFF) begin
            n_fail++; $display("FAIL reset_best got %h want FFFF", best);
        end
        n_checks++;
        if ({result_valid, false_start, timed_out, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got rv/fs/to/busy=%b want 0000",
                     {result_valid, false_start, timed_out, busy});
        end
    endtask

    task automatic test_false_start();
        logic [7:0] exp_delay;
        exp_t exp, obs;
        int lat;
        exp_delay = (m_lfsr < 8'd32) ? 8'd32 : m_lfsr;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (delay_num !== exp_delay) begin
            n_fail++; $display("FAIL fs_delay_num got %0d want %0d", delay_num, exp_delay);
        end
        step();
        repeat (3) step();
        exp_q.push_back('{rt: 16'd0, fs: 1'b1, to: 1'b0, best: 16'hFFFF});
        react = 1'b1;
        wait_rv(10, lat);
        n_checks++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL fs_latency got %0d want 1", lat);
        end
        n_checks++;
        if (lighter_en !== 1'b0) begin
            n_fail++; $display("FAIL fs_lighter_drop got %b want 0", lighter_en);
        end
        exp = exp_q.pop_front();
        obs = '{rt: rt, fs: false_start, to: timed_out, best: best};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL fs_result got rt=%0d fs=%b to=%b best=%h want rt=%0d fs=%b to=%b best=%h",
                     obs.rt, obs.fs, obs.to, obs.best, exp.rt, exp.fs, exp.to, exp.best);
        end
        react = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_timeout();
        exp_t exp, obs;
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        wait_led(300, n);
        step();
        exp_q.push_back('{rt: TB_TIMEOUT, fs: 1'b0, to: 1'b1, best: 16'hFFFF});
        wait_rv(200, n);
        n_checks++;
        if (n !== 81) begin
            n_fail++; $display("FAIL to_latency got %0d want 81", n);
        end
        exp = exp_q.pop_front();
        obs = '{rt: rt, fs: false_start, to: timed_out, best: best};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL to_result got rt=%0d fs=%b to=%b best=%h want rt=%0d fs=%b to=%b best=%h",
                     obs.rt, obs.fs, obs.to, obs.best, exp.rt, exp.fs, exp.to, exp.best);
        end
        repeat (3) step();
    endtask

    // One full run: react_at is the MEASURE cycle holding the press edge.
    task automatic test_measure(input string tag, input bit want_lfsr5, input int react_at,
                                input logic [15:0] exp_best);
        logic [7:0] exp_delay;
        exp_t exp, obs;
        int n;
        if (want_lfsr5) begin
            for (int i = 0; i < 300 && m_lfsr != 8'h05; i++) step();
            n_checks++;
            if (m_lfsr !== 8'h05) begin
                n_fail++; $display("FAIL %s_lfsr_seek got %h want 05", tag, m_lfsr);
            end
        end
        exp_delay = (m_lfsr < 8'd32) ? 8'd32 : m_lfsr;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({delay_num, lighter_en, busy} !== {exp_delay, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL %s_arm got num=%0d en=%b busy=%b want num=%0d en=0 busy=1",
                     tag, delay_num, lighter_en, busy, exp_delay);
        end
        step();
        n_checks++;
        if (lighter_en !== 1'b1) begin
            n_fail++; $display("FAIL %s_lighter_en got %b want 1", tag, lighter_en);
        end
        wait_led(300, n);
        n_checks++;
        if (n !== int'(exp_delay) + 1) begin
            n_fail++; $display("FAIL %s_led_delay got %0d want %0d", tag, n, int'(exp_delay) + 1);
        end
        step();
        repeat (react_at) step();
        exp_q.push_back('{rt: 16'(react_at / TB_TICK_DIV), fs: 1'b0, to: 1'b0, best: exp_best});
        react = 1'b1;
        wait_rv(10, n);
        n_checks++;
        if (n !== 2) begin
            n_fail++; $display("FAIL %s_latency got %0d want 2", tag, n);
        end
        exp = exp_q.pop_front();
        obs = '{rt: rt, fs: false_start, to: timed_out, best: best};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s_result got rt=%0d fs=%b to=%b best=%h want rt=%0d fs=%b to=%b best=%h",
                     tag, obs.rt, obs.fs, obs.to, obs.best, exp.rt, exp.fs, exp.to, exp.best);
        end
        step();
        n_checks++;
        if (result_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_pulse got %b want 0", tag, result_valid);
        end
        react = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_same_cycle();
        exp_t exp, obs;
        int n;
        start = 1'b1;
        step();
        step();
        wait_led(300, n);
        exp_q.push_back('{rt: 16'd0, fs: 1'b0, to: 1'b0, best: 16'd0});
        react = 1'b1;
        wait_rv(10, n);
        n_checks++;
        if (n !== 2) begin
            n_fail++; $display("FAIL same_latency got %0d want 2", n);
        end
        exp = exp_q.pop_front();
        obs = '{rt: rt, fs: false_start, to: timed_out, best: best};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL same_result got rt=%0d fs=%b to=%b best=%h want rt=%0d fs=%b to=%b best=%h",
                     obs.rt, obs.fs, obs.to, obs.best, exp.rt, exp.fs, exp.to, exp.best);
        end
        repeat (8) step();
        n_checks++;
        if ({busy, lighter_en} !== 2'b00) begin
            n_fail++; $display("FAIL held_start_restart got busy/en=%b want 00", {busy, lighter_en});
        end
        start = 1'b0;
        react = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset_mid_measure();
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        wait_led(300, n);
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({lighter_en, delay_num, rt, best, result_valid, false_start, timed_out, busy}
            !== {1'b0, 8'h00, 16'h0000, 16'hFFFF, 4'b0000}) begin
            n_fail++;
            $display("FAIL async_reset got en=%b num=%h rt=%h best=%h rv/fs/to/busy=%b",
                     lighter_en, delay_num, rt, best,
                     {result_valid, false_start, timed_out, busy});
        end
        step();
        step();
        #2;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (led_on !== 1'b0) begin
            n_fail++; $display("FAIL led_after_reset got %b want 0", led_on);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        repeat (2) step();
        test_false_start();
        test_timeout();
        test_measure("run10", 1'b1, 40, 16'd10);
        test_measure("run15", 1'b0, 60, 16'd10);
        test_same_cycle();
        test_reset_mid_measure();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
